// File: rtl/riscvibe_mem_arbiter_if.sv
// Bus bundle between the IF/MEM-stage requesters, the memory arbiter and the unified memory.
// The master modport is the arbiter's view; the slave modport is the requesters' and memory's view.
interface riscvibe_mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_done;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;

  logic        m_req;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ack;
  logic [31:0] m_rdata;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_ack, m_rdata,
    output i_done, i_rdata, d_done, d_rdata, m_req, m_we, m_be, m_addr, m_wdata
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_ack, m_rdata,
    input  i_done, i_rdata, d_done, d_rdata, m_req, m_we, m_be, m_addr, m_wdata
  );
endinterface

// File: rtl/riscvibe_mem_arbiter.sv
// Single-port memory arbiter: one outstanding fetch or data transaction, watchdog-bounded.
// Define RISCVIBE_ARB_RR_EN for round-robin on contention; default is fixed data-port priority.
module riscvibe_mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  riscvibe_mem_arbiter_if.master bus,
  output logic                   err,
  input  logic                   err_clr
);

  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_BUSY_I = 2'd1;
  localparam logic [1:0]  ST_BUSY_D = 2'd2;
  localparam logic [15:0] TO_VAL    = 16'(TIMEOUT);

  logic [1:0]  state;
  logic [15:0] cnt;
  logic        idle, busy_i, busy_d, busy;
  logic        to_hit, complete;
  logic        grant_i, grant_d;

  assign idle   = (state == ST_IDLE);
  assign busy_i = (state == ST_BUSY_I);
  assign busy_d = (state == ST_BUSY_D);
  assign busy   = busy_i || busy_d;

  // A zero TIMEOUT keeps cnt at 0 but to_hit is masked, so the watchdog never fires.
  assign to_hit   = (TO_VAL != 16'd0) && busy && (cnt == TO_VAL) && !bus.m_ack;
  assign complete = busy && (bus.m_ack || to_hit);

  assign bus.i_done  = busy_i && complete;
  assign bus.d_done  = busy_d && complete;
  assign bus.i_rdata = (busy_i && bus.m_ack) ? bus.m_rdata : 32'h0;
  assign bus.d_rdata = (busy_d && bus.m_ack) ? bus.m_rdata : 32'h0;

`ifdef RISCVIBE_ARB_RR_EN
  logic last_d;

  assign grant_d = idle && bus.d_req && (!bus.i_req || !last_d);
  assign grant_i = idle && bus.i_req && !grant_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d <= 1'b0;
    end else if (grant_d) begin
      last_d <= 1'b1;
    end else if (grant_i) begin
      last_d <= 1'b0;
    end
  end
`else
  assign grant_d = idle && bus.d_req;
  assign grant_i = idle && bus.i_req && !bus.d_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= 16'd0;
      bus.m_req   <= 1'b0;
      bus.m_we    <= 1'b0;
      bus.m_be    <= 4'h0;
      bus.m_addr  <= 32'h0;
      bus.m_wdata <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= 16'd0;
          if (grant_d) begin
            state       <= ST_BUSY_D;
            bus.m_req   <= 1'b1;
            bus.m_we    <= bus.d_we;
            bus.m_be    <= bus.d_be;
            bus.m_addr  <= bus.d_addr;
            bus.m_wdata <= bus.d_wdata;
          end else if (grant_i) begin
            state       <= ST_BUSY_I;
            bus.m_req   <= 1'b1;
            bus.m_we    <= 1'b0;
            bus.m_be    <= 4'hF;
            bus.m_addr  <= bus.i_addr;
            bus.m_wdata <= 32'h0;
          end
        end
        ST_BUSY_I, ST_BUSY_D: begin
          if (complete) begin
            state     <= ST_IDLE;
            bus.m_req <= 1'b0;
            cnt       <= 16'd0;
          end else if (cnt != TO_VAL) begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          bus.m_req <= 1'b0;
          cnt       <= 16'd0;
        end
      endcase
    end
  end

  // A timeout in the same cycle as err_clr leaves err set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (to_hit) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_riscvibe_mem_arbiter.sv
// Directed bench for riscvibe_mem_arbiter with TIMEOUT=4: fetch, store, contention,
// watchdog timeout with err set/clear, and reset in the middle of a data transaction.
module tb_riscvibe_mem_arbiter;

  logic clk;
  logic rst_n;
  logic err;
  logic err_clr;
  int   n_chk;
  int   n_pass;
  int   done_cnt;

  riscvibe_mem_arbiter_if bus ();

  riscvibe_mem_arbiter #(.TIMEOUT(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .err     (err),
    .err_clr (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef RISCVIBE_ARB_RR_EN
  // Last grant before the contention is the store, so round-robin favours fetch.
  localparam bit FIRST_D = 1'b0;
`else
  localparam bit FIRST_D = 1'b1;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    rst_n = 1'b0; err_clr = 1'b0;
    bus.i_req = 1'b0; bus.i_addr = 32'h0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = 4'h0;
    bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
    bus.m_ack = 1'b0; bus.m_rdata = 32'h0;

    step();
    smp();
    check("rst_m_req",   32'(bus.m_req), 32'h0);
    check("rst_m_we",    32'(bus.m_we),  32'h0);
    check("rst_m_be",    32'(bus.m_be),  32'h0);
    check("rst_m_addr",  bus.m_addr,     32'h0);
    check("rst_m_wdata", bus.m_wdata,    32'h0);
    check("rst_i_done",  32'(bus.i_done), 32'h0);
    check("rst_d_done",  32'(bus.d_done), 32'h0);
    check("rst_err",     32'(err),       32'h0);
    step();
    rst_n = 1'b1;

    // m_ack while idle must not produce a done
    bus.m_ack = 1'b1; bus.m_rdata = 32'h1234_5678;
    smp();
    check("idle_ack_i_done", 32'(bus.i_done), 32'h0);
    check("idle_ack_d_done", 32'(bus.d_done), 32'h0);
    check("idle_ack_d_rdata", bus.d_rdata, 32'h0);
    step();
    bus.m_ack = 1'b0; bus.m_rdata = 32'h0;

    // fetch only
    bus.i_req = 1'b1; bus.i_addr = 32'h100;
    smp();
    check("f_idle_done", 32'(bus.i_done), 32'h0);
    step();
    smp();
    check("f_m_req",  32'(bus.m_req), 32'h1);
    check("f_m_addr", bus.m_addr,     32'h100);
    check("f_m_be",   32'(bus.m_be),  32'hF);
    check("f_m_we",   32'(bus.m_we),  32'h0);
    check("f_early_done", 32'(bus.i_done), 32'h0);
    step();
    bus.m_ack = 1'b1; bus.m_rdata = 32'h0050_0093;
    smp();
    check("f_done",  32'(bus.i_done), 32'h1);
    check("f_rdata", bus.i_rdata,     32'h0050_0093);
    check("f_d_done", 32'(bus.d_done), 32'h0);
    step();
    bus.m_ack = 1'b0; bus.m_rdata = 32'h0; bus.i_req = 1'b0;
    smp();
    check("f_after_m_req", 32'(bus.m_req), 32'h0);
    check("f_after_done",  32'(bus.i_done), 32'h0);

    // store, ack on the 4th busy cycle
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'b0011;
    bus.d_addr = 32'h204; bus.d_wdata = 32'hDEAD_BEEF;
    done_cnt = 0;
    for (int k = 1; k <= 4; k++) begin
      step();
      bus.m_ack = (k == 4);
      smp();
      done_cnt += int'(bus.d_done);
      if (k == 1) begin
        check("st_m_req",   32'(bus.m_req), 32'h1);
        check("st_m_we",    32'(bus.m_we),  32'h1);
        check("st_m_be",    32'(bus.m_be),  32'h3);
        check("st_m_addr",  bus.m_addr,     32'h204);
        check("st_m_wdata", bus.m_wdata,    32'hDEAD_BEEF);
      end
      if (k == 4) begin
        check("st_done",  32'(bus.d_done), 32'h1);
        check("st_rdata", bus.d_rdata,     32'h0);
        check("st_m_addr_hold", bus.m_addr, 32'h204);
      end
    end
    step();
    bus.m_ack = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    smp();
    done_cnt += int'(bus.d_done);
    check("st_done_count", 32'(done_cnt), 32'h1);
    check("st_after_m_req", 32'(bus.m_req), 32'h0);

    // contention: both requests rise in the same idle cycle
    bus.i_req = 1'b1; bus.i_addr = 32'h300;
    bus.d_req = 1'b1; bus.d_be = 4'hF; bus.d_addr = 32'h400; bus.d_wdata = 32'h0;
    step();
    smp();
    check("c1_m_req",  32'(bus.m_req), 32'h1);
    check("c1_m_addr", bus.m_addr, FIRST_D ? 32'h400 : 32'h300);
    step();
    bus.m_ack = 1'b1; bus.m_rdata = 32'hAAAA_0001;
    smp();
    check("c1_d_done", 32'(bus.d_done), 32'(FIRST_D));
    check("c1_i_done", 32'(bus.i_done), 32'(!FIRST_D));
    check("c1_rdata", FIRST_D ? bus.d_rdata : bus.i_rdata, 32'hAAAA_0001);
    step();
    bus.m_ack = 1'b0; bus.m_rdata = 32'h0;
    if (FIRST_D) bus.d_req = 1'b0; else bus.i_req = 1'b0;
    smp();
    check("c_gap_m_req",  32'(bus.m_req), 32'h0);
    check("c_gap_i_done", 32'(bus.i_done), 32'h0);
    check("c_gap_d_done", 32'(bus.d_done), 32'h0);
    step();
    smp();
    check("c2_m_req",  32'(bus.m_req), 32'h1);
    check("c2_m_addr", bus.m_addr, FIRST_D ? 32'h300 : 32'h400);
    check("c2_m_be",   32'(bus.m_be), 32'hF);
    step();
    bus.m_ack = 1'b1; bus.m_rdata = 32'hBBBB_0002;
    smp();
    check("c2_i_done", 32'(bus.i_done), 32'(FIRST_D));
    check("c2_d_done", 32'(bus.d_done), 32'(!FIRST_D));
    check("c2_rdata", FIRST_D ? bus.i_rdata : bus.d_rdata, 32'hBBBB_0002);
    step();
    bus.m_ack = 1'b0; bus.m_rdata = 32'h0; bus.i_req = 1'b0; bus.d_req = 1'b0;
    smp();
    check("c_after_m_req", 32'(bus.m_req), 32'h0);

    // watchdog: no ack, forced completion on the 5th busy cycle
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h500;
    bus.m_rdata = 32'hFFFF_FFFF;
    done_cnt = 0;
    for (int k = 1; k <= 5; k++) begin
      step();
      smp();
      if (k < 5) done_cnt += int'(bus.d_done);
      else begin
        check("to_early_done", 32'(done_cnt), 32'h0);
        check("to_done",  32'(bus.d_done), 32'h1);
        check("to_rdata", bus.d_rdata,     32'h0);
        check("to_err_pre", 32'(err),      32'h0);
      end
    end
    step();
    bus.d_req = 1'b0; bus.m_rdata = 32'h0;
    smp();
    check("to_err_set", 32'(err),       32'h1);
    check("to_m_req",   32'(bus.m_req), 32'h0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    smp();
    check("to_err_clr", 32'(err), 32'h0);

    // reset in the middle of a data transaction, fetch pending
    bus.d_req = 1'b1; bus.d_addr = 32'h600;
    step();
    bus.i_req = 1'b1; bus.i_addr = 32'h700;
    smp();
    check("rm_busy_m_req", 32'(bus.m_req), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rm_m_req_async", 32'(bus.m_req), 32'h0);
    check("rm_d_done",      32'(bus.d_done), 32'h0);
    step();
    bus.d_req = 1'b0;
    smp();
    check("rm_d_done_hold", 32'(bus.d_done), 32'h0);
    step();
    rst_n = 1'b1;
    smp();
    check("rm_rel_m_req", 32'(bus.m_req), 32'h0);
    step();
    smp();
    check("rm_f_m_req",  32'(bus.m_req), 32'h1);
    check("rm_f_m_addr", bus.m_addr,     32'h700);
    step();
    bus.m_ack = 1'b1; bus.m_rdata = 32'hC0DE_0003;
    smp();
    check("rm_f_done",  32'(bus.i_done), 32'h1);
    check("rm_f_rdata", bus.i_rdata,     32'hC0DE_0003);
    step();
    bus.m_ack = 1'b0; bus.m_rdata = 32'h0; bus.i_req = 1'b0;
    smp();
    check("rm_f_after", 32'(bus.m_req), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
